reg_file_sequencer: RTL and testbench

//  Multi-cycle control FSM for the 8-bit core: fetches one/two-byte instructions from program memory

---
 rtl/reg_file_sequencer_if.sv | 13 +
 rtl/reg_file_sequencer.sv | 163 ++++++++++++++++
 tb/tb_reg_file_sequencer.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_file_sequencer_if.sv
// Program-memory fetch bus between the sequencer (master) and instruction memory (slave).
// Each request is held until a single-cycle ack that carries the data byte.
interface reg_file_sequencer_if #(
  parameter int PC_W = 8
);
  logic [PC_W-1:0] imem_addr;
  logic            imem_req;
  logic            imem_ack;
  logic [7:0]      imem_data;

  modport master (output imem_addr, output imem_req, input imem_ack, input imem_data);
  modport slave  (input imem_addr, input imem_req, output imem_ack, output imem_data);
endinterface

// File: rtl/reg_file_sequencer.sv
// Fetch/decode/execute controller for the 8-bit core: fetches one- or two-byte instructions
// and drives the register file and accumulator strobes, select, source mux and ALU op.
//
// state   | meaning
// IDLE    | waiting for run
// FETCH   | opcode request outstanding at PC
// DECODE  | latch select, choose operand fetch / halt / illegal / execute
// OPFETCH | operand byte request outstanding at PC
// EXEC    | one-cycle strobe, jump resolution
// HALT    | stopped until reset
module reg_file_sequencer #(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                Reg_clk,
  input  logic                Reg_rst_n,
  input  logic                run,
  reg_file_sequencer_if.master imem,
  output logic [1:0]          select,
  output logic                RF_we,
  output logic                Acc_we,
  output logic [1:0]          acc_src,
  output logic [7:0]          imm_out,
  output logic [2:0]          alu_op,
  input  logic                alu_zero,
  output logic                halted,
  output logic                illegal
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_OPFETCH, S_EXEC, S_HALT
  } state_t;

  state_t          state;
  logic [PC_W-1:0] pc;
  logic [7:0]      ir;
  logic            z;
  logic            req;
  logic [3:0]      opc;
  logic            nxt_rf_we;
  logic            nxt_acc_we;
  logic [1:0]      nxt_src;
  logic [2:0]      nxt_op;
  logic            unused_ir_bits;

  assign opc            = ir[7:4];
  assign unused_ir_bits = ^ir[3:2];
  assign imem.imem_addr = pc;
  assign imem.imem_req  = req;

  // Strobe pattern loaded on the edge that enters EXEC, so it is visible for exactly that cycle.
  always_comb begin
    nxt_rf_we  = 1'b0;
    nxt_acc_we = 1'b0;
    nxt_src    = acc_src;
    nxt_op     = alu_op;
    case (opc)
      4'h1: begin
        nxt_acc_we = 1'b1;
        nxt_src    = 2'b01;
      end
      4'h2: nxt_rf_we = 1'b1;
      4'h3, 4'h4, 4'h5, 4'h6, 4'h7: begin
        nxt_acc_we = 1'b1;
        nxt_src    = 2'b00;
        nxt_op     = 3'(opc - 4'd3);
      end
      4'h8: begin
        nxt_acc_we = 1'b1;
        nxt_src    = 2'b10;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Reg_clk or negedge Reg_rst_n) begin
    if (!Reg_rst_n) begin
      state   <= S_IDLE;
      pc      <= RESET_PC;
      ir      <= '0;
      imm_out <= '0;
      z       <= 1'b0;
      req     <= 1'b0;
      select  <= '0;
      RF_we   <= 1'b0;
      Acc_we  <= 1'b0;
      acc_src <= '0;
      alu_op  <= '0;
      halted  <= 1'b0;
      illegal <= 1'b0;
    end else begin
      RF_we   <= 1'b0;
      Acc_we  <= 1'b0;
      illegal <= 1'b0;
      if (Acc_we) z <= alu_zero;
      case (state)
        S_IDLE: begin
          if (run) begin
            state <= S_FETCH;
            req   <= 1'b1;
          end
        end
        S_FETCH: begin
          if (imem.imem_ack) begin
            ir    <= imem.imem_data;
            pc    <= pc + PC_W'(1);
            req   <= 1'b0;
            state <= S_DECODE;
          end
        end
        S_DECODE: begin
          select <= ir[1:0];
          case (opc)
            4'h8, 4'h9, 4'hA: begin
              state <= S_OPFETCH;
              req   <= 1'b1;
            end
            4'hF: begin
              state  <= S_HALT;
              halted <= 1'b1;
            end
            4'hB, 4'hC, 4'hD, 4'hE: begin
              illegal <= 1'b1;
              state   <= S_FETCH;
              req     <= 1'b1;
            end
            default: begin
              state   <= S_EXEC;
              RF_we   <= nxt_rf_we;
              Acc_we  <= nxt_acc_we;
              acc_src <= nxt_src;
              alu_op  <= nxt_op;
            end
          endcase
        end
        S_OPFETCH: begin
          if (imem.imem_ack) begin
            imm_out <= imem.imem_data;
            pc      <= pc + PC_W'(1);
            req     <= 1'b0;
            state   <= S_EXEC;
            RF_we   <= nxt_rf_we;
            Acc_we  <= nxt_acc_we;
            acc_src <= nxt_src;
            alu_op  <= nxt_op;
          end
        end
        S_EXEC: begin
          if (opc == 4'h9 || (opc == 4'hA && z)) pc <= PC_W'(imm_out);
          if (run) begin
            state <= S_FETCH;
            req   <= 1'b1;
          end else begin
            state <= S_IDLE;
          end
        end
        S_HALT: ;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_file_sequencer.sv
// Bench for reg_file_sequencer: memory responder with random ack delay, a small accumulator/register
// datapath, and an instruction-level reference model producing expected fetches and strobes.
module tb_reg_file_sequencer;
  localparam int PC_W = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       run;
  logic [1:0] select;
  logic       RF_we, Acc_we;
  logic [1:0] acc_src;
  logic [7:0] imm_out;
  logic [2:0] alu_op;
  logic       alu_zero, halted, illegal;

  reg_file_sequencer_if #(.PC_W(PC_W)) imem_bus ();

  reg_file_sequencer #(.PC_W(PC_W), .RESET_PC('0)) dut (
    .Reg_clk(clk), .Reg_rst_n(rst_n), .run(run), .imem(imem_bus),
    .select(select), .RF_we(RF_we), .Acc_we(Acc_we), .acc_src(acc_src),
    .imm_out(imm_out), .alu_op(alu_op), .alu_zero(alu_zero),
    .halted(halted), .illegal(illegal)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int mk_ev(int kind, int sel, int src, int op);
    return (kind << 7) | (sel << 5) | (src << 3) | op;
  endfunction

  logic [7:0] mem [256];

  // Memory bus: responder drives during program runs, directed tests drive otherwise.
  bit         resp_en = 0;
  bit         mon_en  = 0;
  logic       r_ack = 1'b0, d_ack = 1'b0;
  logic [7:0] r_data = '0, d_data = '0;
  assign imem_bus.imem_ack  = resp_en ? r_ack : d_ack;
  assign imem_bus.imem_data = resp_en ? r_data : d_data;

  // Accumulator / register-file datapath that the sequencer steers.
  logic [7:0] acc_m;
  logic [7:0] rf_m [4];
  logic [7:0] dp_result;
  always_comb begin
    dp_result = 8'h00;
    case (acc_src)
      2'b00: case (alu_op)
        3'd0: dp_result = acc_m + rf_m[select];
        3'd1: dp_result = acc_m - rf_m[select];
        3'd2: dp_result = acc_m & rf_m[select];
        3'd3: dp_result = acc_m | rf_m[select];
        3'd4: dp_result = acc_m ^ rf_m[select];
        default: dp_result = 8'h00;
      endcase
      2'b01: dp_result = rf_m[select];
      2'b10: dp_result = imm_out;
      default: dp_result = 8'h00;
    endcase
  end
  assign alu_zero = (dp_result == 8'h00);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_m <= 8'h00;
      for (int i = 0; i < 4; i++) rf_m[i] <= 8'h00;
    end else begin
      if (Acc_we) acc_m <= dp_result;
      if (RF_we) rf_m[select] <= acc_m;
    end
  end

  int         obs_ev[$];
  int         obs_fetch[$];
  int         exp_ev[$];
  int         exp_fetch[$];
  int         exp_pc;
  bit         exp_halt;
  int         delay_mode = 0;
  int         cur_delay = 0;
  int         wait_cnt = 0;
  bit         prev_wait = 0;
  logic [7:0] prev_addr = '0;
  bit         prev_ill = 0;

  initial forever begin
    @(negedge clk);
    if (resp_en) begin
      if (prev_wait) begin
        check_val("req_held", imem_bus.imem_req, 1);
        check_val("addr_stable", imem_bus.imem_addr, prev_addr);
      end
      if (imem_bus.imem_req && wait_cnt >= cur_delay) begin
        r_ack  = 1'b1;
        r_data = mem[imem_bus.imem_addr];
        obs_fetch.push_back(int'(imem_bus.imem_addr));
        wait_cnt  = 0;
        cur_delay = (delay_mode != 0) ? 3 : $urandom_range(0, 3);
        prev_wait = 0;
      end else if (imem_bus.imem_req) begin
        r_ack     = 1'b0;
        wait_cnt++;
        prev_wait = 1;
        prev_addr = imem_bus.imem_addr;
      end else begin
        r_ack     = 1'b0;
        wait_cnt  = 0;
        prev_wait = 0;
      end
    end
    if (mon_en) begin
      if (RF_we || Acc_we) begin
        check_val("strobe_excl", {31'b0, RF_we && Acc_we}, 0);
        if (RF_we) obs_ev.push_back(mk_ev(1, int'(select), 0, 0));
        else obs_ev.push_back(mk_ev(2, int'(select), int'(acc_src),
                                    (acc_src == 2'b00) ? int'(alu_op) : 0));
      end
      if (illegal) begin
        check_val("ill_pulse", {31'b0, prev_ill}, 0);
        obs_ev.push_back(mk_ev(3, 0, 0, 0));
      end
      prev_ill = illegal;
    end
  end

  // Instruction-level reference: executes the program image directly.
  task automatic model_run();
    logic [7:0] pc, acc, imm, b;
    logic [7:0] r [4];
    logic [3:0] op;
    int         n;
    bit         z;
    pc = 0; acc = 0; imm = 0; z = 0;
    for (int i = 0; i < 4; i++) r[i] = 0;
    exp_ev.delete();
    exp_fetch.delete();
    exp_halt = 0;
    for (int step = 0; step < 500; step++) begin
      b = mem[pc];
      exp_fetch.push_back(int'(pc));
      pc = pc + 8'd1;
      op = b[7:4];
      n  = int'(b[1:0]);
      if (op == 4'h8 || op == 4'h9 || op == 4'hA) begin
        imm = mem[pc];
        exp_fetch.push_back(int'(pc));
        pc = pc + 8'd1;
      end
      case (op)
        4'h0: ;
        4'h1: begin acc = r[n]; z = (acc == 0); exp_ev.push_back(mk_ev(2, n, 1, 0)); end
        4'h2: begin r[n] = acc; exp_ev.push_back(mk_ev(1, n, 0, 0)); end
        4'h3, 4'h4, 4'h5, 4'h6, 4'h7: begin
          case (op)
            4'h3: acc = acc + r[n];
            4'h4: acc = acc - r[n];
            4'h5: acc = acc & r[n];
            4'h6: acc = acc | r[n];
            default: acc = acc ^ r[n];
          endcase
          z = (acc == 0);
          exp_ev.push_back(mk_ev(2, n, 0, int'(op) - 3));
        end
        4'h8: begin acc = imm; z = (acc == 0); exp_ev.push_back(mk_ev(2, n, 2, 0)); end
        4'h9: pc = imm;
        4'hA: if (z) pc = imm;
        4'hF: begin exp_halt = 1; break; end
        default: exp_ev.push_back(mk_ev(3, 0, 0, 0));
      endcase
    end
    exp_pc = int'(pc);
  endtask

  task automatic fill_mem(input logic [7:0] val);
    for (int i = 0; i < 256; i++) mem[i] = val;
  endtask

  task automatic run_program(input string tag, input bit toggle_run);
    int cyc;
    int f0;
    resp_en = 0; mon_en = 0; rst_n = 0; run = 0;
    model_run();
    repeat (2) @(negedge clk);
    obs_ev.delete();
    obs_fetch.delete();
    wait_cnt = 0; prev_wait = 0; prev_ill = 0;
    cur_delay = (delay_mode != 0) ? 3 : $urandom_range(0, 3);
    rst_n = 1; resp_en = 1; mon_en = 1; run = 1;
    cyc = 0;
    while (!halted && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      if (toggle_run) run = ($urandom_range(0, 4) != 0);
    end
    run = 1;
    repeat (3) @(negedge clk);
    check_val({tag, "_halted"}, {31'b0, halted}, {31'b0, exp_halt});
    check_val({tag, "_pc"}, imem_bus.imem_addr, exp_pc);
    check_val({tag, "_nfetch"}, obs_fetch.size(), exp_fetch.size());
    check_val({tag, "_nev"}, obs_ev.size(), exp_ev.size());
    f0 = n_fail;
    for (int i = 0; i < obs_fetch.size() && i < exp_fetch.size() && n_fail == f0; i++)
      check_val({tag, "_fetch"}, obs_fetch[i], exp_fetch[i]);
    f0 = n_fail;
    for (int i = 0; i < obs_ev.size() && i < exp_ev.size() && n_fail == f0; i++)
      check_val({tag, "_ev"}, obs_ev[i], exp_ev[i]);
    resp_en = 0; mon_en = 0;
  endtask

  task automatic gen_random();
    int         n, a, t;
    logic [3:0] ops  [32];
    int         addr [33];
    logic [3:0] lo;
    fill_mem(8'hF0);
    n = $urandom_range(6, 20);
    a = 0;
    for (int i = 0; i < n; i++) begin
      ops[i]  = 4'($urandom_range(0, 14));
      addr[i] = a;
      a += (ops[i] == 4'h8 || ops[i] == 4'h9 || ops[i] == 4'hA) ? 2 : 1;
    end
    addr[n] = a;
    for (int i = 0; i < n; i++) begin
      lo = 4'($urandom_range(0, 15));
      mem[addr[i]] = {ops[i], lo};
      if (ops[i] == 4'h8)
        mem[addr[i] + 1] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      if (ops[i] == 4'h9 || ops[i] == 4'hA) begin
        t = $urandom_range(i + 1, n);
        mem[addr[i] + 1] = 8'(addr[t]);
      end
    end
    lo = 4'($urandom_range(0, 15));
    mem[addr[n]] = {4'hF, lo};
  endtask

  initial begin
    rst_n = 0; run = 0;
    fill_mem(8'h00);
    @(negedge clk);
    check_val("rst_req", imem_bus.imem_req, 0);
    check_val("rst_addr", imem_bus.imem_addr, 0);
    check_val("rst_halted", halted, 0);
    check_val("rst_strobes", {RF_we, Acc_we, illegal}, 0);
    check_val("rst_select", select, 0);
    check_val("rst_imm", imm_out, 0);
    check_val("rst_src_op", {acc_src, alu_op}, 0);

    // Reset while a fetch is outstanding, then a stale ack arriving in IDLE.
    rst_n = 1; run = 1;
    repeat (3) @(negedge clk);
    check_val("midfetch_req", imem_bus.imem_req, 1);
    check_val("midfetch_addr", imem_bus.imem_addr, 0);
    #2 rst_n = 0;
    #1;
    check_val("midrst_req", imem_bus.imem_req, 0);
    check_val("midrst_addr", imem_bus.imem_addr, 0);
    check_val("midrst_halted", halted, 0);
    check_val("midrst_strobes", {RF_we, Acc_we}, 0);
    @(negedge clk);
    d_ack = 1; d_data = 8'h21; run = 0;
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    d_ack = 0;
    repeat (3) @(negedge clk);
    check_val("late_ack_req", imem_bus.imem_req, 0);
    check_val("late_ack_addr", imem_bus.imem_addr, 0);
    check_val("late_ack_strobes", {RF_we, Acc_we, halted}, 0);

    // LDI 5; STA B; ADD B; HLT with immediate and with 3-cycle acks.
    fill_mem(8'hF0);
    mem[0] = 8'h80; mem[1] = 8'h05; mem[2] = 8'h21; mem[3] = 8'h31; mem[4] = 8'hF0;
    delay_mode = 0;
    run_program("spec", 0);
    check_val("spec_pc_const", imem_bus.imem_addr, 5);
    check_val("spec_ev1", (obs_ev.size() > 1) ? obs_ev[1] : -1, mk_ev(1, 1, 0, 0));
    delay_mode = 1;
    run_program("spec_slow", 0);
    check_val("spec_slow_nev", obs_ev.size(), 3);

    // SUB to zero then JZ taken; ADD then JZ falls through.
    delay_mode = 0;
    fill_mem(8'hF0);
    mem[0] = 8'h80; mem[1] = 8'h03; mem[2] = 8'h20; mem[3] = 8'h40;
    mem[4] = 8'hA0; mem[5] = 8'h10;
    run_program("jz_taken", 0);
    check_val("jz_taken_pc", imem_bus.imem_addr, 8'h11);
    mem[3] = 8'h30;
    run_program("jz_fall", 0);
    check_val("jz_fall_pc", imem_bus.imem_addr, 8'h07);

    // Undefined opcode.
    fill_mem(8'hF0);
    mem[0] = 8'hC3;
    run_program("illegal", 0);
    check_val("illegal_pc", imem_bus.imem_addr, 2);
    check_val("illegal_ev", (obs_ev.size() > 0) ? obs_ev[0] : -1, mk_ev(3, 0, 0, 0));

    // Jump to 0xFF with a two-byte op there: operand fetch wraps to 0x00.
    fill_mem(8'hF0);
    mem[0] = 8'h80; mem[1] = 8'h00; mem[2] = 8'hA0; mem[3] = 8'hFF; mem[4] = 8'hF0;
    mem[8'hFF] = 8'h80;
    run_program("wrap", 1);
    check_val("wrap_fetch_ff", (obs_fetch.size() > 5) ? obs_fetch[4] : -1, 8'hFF);
    check_val("wrap_fetch_00", (obs_fetch.size() > 5) ? obs_fetch[5] : -1, 8'h00);
    check_val("wrap_pc", imem_bus.imem_addr, 5);

    for (int k = 0; k < 25; k++) begin
      gen_random();
      delay_mode = $urandom_range(0, 1);
      run_program("rand", 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
